// File: rtl/ex_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// ex_muldiv_ctrl
//
// Multi-cycle RV32M multiply/divide sequencer that sits beside the EX stage.
// An M-extension instruction in EX is latched and worked on one bit per
// cycle. A shift-add multiplier handles MUL*. A restoring divider handles
// DIV*/REM*. While the unit works it holds the front of the pipeline with
// stall. When the answer is ready it pulses done for one cycle, together
// with the result and the rd it belongs to.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   md_valid  EX holds an M-extension instruction
//   func3     operation select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   Read1     rs1 operand
//   Read2     rs2 operand
//   rd        destination register of the instruction in EX
//   flush     kills the in-flight operation (branch/jump redirect)
//   stall     holds the IF/ID/EX pipeline registers
//   busy      sequencer is not idle
//   done      one-cycle pulse: result and rd_MD are valid
//   result    operation result; holds its value until the next completion
//   rd_MD     rd of the completed operation; holds its value like result
// ----------------------------------------------------------------------------
module ex_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_valid,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] Read1,
    input  logic [XLEN-1:0] Read2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_MD
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [2:0]        r_func3;
    logic [XLEN-1:0]   r_opA;
    logic [XLEN-1:0]   r_opB;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_magA;
    logic [XLEN-1:0]   r_magB;
    logic              r_negRes;
    logic              r_negRem;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rdMD;
    logic              r_done;

    logic              w_isDiv;
    logic              w_aSigned;
    logic              w_bSigned;
    logic              w_aNeg;
    logic              w_bNeg;
    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic              w_divZero;
    logic              w_overflow;
    logic              w_fastPath;
    logic [XLEN-1:0]   w_fastResult;
    logic [XLEN:0]     w_addHi;
    logic [2*XLEN-1:0] w_prodNext;
    logic [XLEN:0]     w_remShift;
    logic [XLEN+1:0]   w_diff;
    logic              w_diffNeg;
    logic [2*XLEN-1:0] w_prodSigned;
    logic [XLEN-1:0]   w_quotSigned;
    logic [XLEN-1:0]   w_remSigned;
    logic [XLEN-1:0]   w_fixResult;
    logic [XLEN-1:0]   w_resultNext;

    // Operand preparation from the latched instruction. MUL is treated as
    // unsigned because the low word of the product does not depend on the
    // signedness of the operands. Only rs1 of MULHSU is signed.
    assign w_isDiv   = r_func3[2];
    assign w_aSigned = (r_func3 == 3'b001) || (r_func3 == 3'b010) ||
                       (r_func3 == 3'b100) || (r_func3 == 3'b110);
    assign w_bSigned = (r_func3 == 3'b001) || (r_func3 == 3'b100) ||
                       (r_func3 == 3'b110);
    assign w_aNeg    = w_aSigned & r_opA[XLEN-1];
    assign w_bNeg    = w_bSigned & r_opB[XLEN-1];
    assign w_absA    = w_aNeg ? -r_opA : r_opA;
    assign w_absB    = w_bNeg ? -r_opB : r_opB;

    // Divide corner cases have fixed architectural answers, so they skip the
    // iteration entirely. func3[1] tells REM/REMU apart from DIV/DIVU, and
    // func3[0] marks the unsigned forms. Overflow can only happen on signed ops.
    assign w_divZero  = w_isDiv && (r_opB == '0);
    assign w_overflow = w_isDiv && !r_func3[0] &&
                        (r_opA == {1'b1, {(XLEN-1){1'b0}}}) && (r_opB == '1);
    assign w_fastPath = w_divZero || w_overflow;

    always_comb begin
        w_fastResult = '0;
        if (w_divZero)
            w_fastResult = r_func3[1] ? r_opA : '1;
        else if (w_overflow)
            w_fastResult = r_func3[1] ? '0 : r_opA;
    end

    // One shift-add multiply step. The multiplier sits in the low half of
    // r_prod and is consumed from bit 0 as the partial product shifts in from
    // the top. The carry out of the add becomes the new top bit.
    assign w_addHi    = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                        (r_prod[0] ? {1'b0, r_magA} : '0);
    assign w_prodNext = {w_addHi, r_prod[XLEN-1:1]};

    // One restoring divide step. The dividend shifts out of r_quot MSB first
    // into the remainder, and quotient bits shift into r_quot from the bottom.
    // The subtraction has an extra bit so that its sign shows whether to restore.
    assign w_remShift = {r_rem[XLEN-1:0], r_quot[XLEN-1]};
    assign w_diff     = {1'b0, w_remShift} - {2'b00, r_magB};
    assign w_diffNeg  = w_diff[XLEN+1];

    // Sign fix-up and output select after the iterations are finished.
    assign w_prodSigned = r_negRes ? -r_prod : r_prod;
    assign w_quotSigned = r_negRes ? -r_quot : r_quot;
    assign w_remSigned  = r_negRem ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

    always_comb begin
        w_fixResult = '0;
        if (w_isDiv)
            w_fixResult = r_func3[1] ? w_remSigned : w_quotSigned;
        else if (r_func3 == 3'b000)
            w_fixResult = w_prodSigned[XLEN-1:0];
        else
            w_fixResult = w_prodSigned[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Next-state logic and pipeline handshake. Flush overrides every
    // transition. The result value is picked only on the edges that enter DONE.
    // stall falls in DONE, so EX advances on the same edge the sequencer goes
    // back to IDLE and the same instruction is never taken twice.
    always_comb begin
        w_nextState  = r_state;
        w_resultNext = r_result;
        stall        = md_valid && (r_state != DONE);
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (md_valid)
                    w_nextState = PREP;
            end
            PREP: begin
                if (w_fastPath) begin
                    w_nextState  = DONE;
                    w_resultNext = w_fastResult;
                end else begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                if (r_count == CW'(1))
                    w_nextState = FIX;
            end
            FIX: begin
                w_nextState  = DONE;
                w_resultNext = w_fixResult;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (flush)
            w_nextState = IDLE;
    end

    // Datapath registers. done is registered from the next state, so the
    // inputs never reach it combinationally. A flushed operation never enters
    // DONE, so result and rd_MD keep the values from the last completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_func3  <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_rd     <= '0;
            r_magA   <= '0;
            r_magB   <= '0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
            r_count  <= '0;
            r_prod   <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_rdMD   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_nextState == DONE);
            if (w_nextState == DONE) begin
                r_result <= w_resultNext;
                r_rdMD   <= r_rd;
            end
            case (r_state)
                IDLE: begin
                    if (md_valid && !flush) begin
                        r_func3 <= func3;
                        r_opA   <= Read1;
                        r_opB   <= Read2;
                        r_rd    <= rd;
                    end
                end
                PREP: begin
                    r_magA   <= w_absA;
                    r_magB   <= w_absB;
                    r_negRes <= w_aNeg ^ w_bNeg;
                    r_negRem <= w_aNeg;
                    r_count  <= CW'(XLEN);
                    r_prod   <= {{XLEN{1'b0}}, w_absB};
                    r_quot   <= w_absA;
                    r_rem    <= '0;
                end
                CALC: begin
                    r_count <= r_count - 1'b1;
                    if (w_isDiv) begin
                        r_rem  <= w_diffNeg ? w_remShift : w_diff[XLEN:0];
                        r_quot <= {r_quot[XLEN-2:0], ~w_diffNeg};
                    end else begin
                        r_prod <= w_prodNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign rd_MD  = r_rdMD;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_ctrl
//
// Directed bench for the multiply/divide sequencer. The stimulus process acts
// as the EX stage. It presents an instruction and keeps it there while stall
// is high. It pushes the hand-computed answer into a scoreboard queue. An
// independent monitor pops that queue on every done pulse. Latency, stall
// length, flush and reset behaviour are checked inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            md_valid;
    logic [2:0]      func3;
    logic [XLEN-1:0] Read1;
    logic [XLEN-1:0] Read2;
    logic [4:0]      rd;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_MD;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      rdv;
    } exp_t;

    exp_t            expQ[$];
    exp_t            monExp;
    int              testsRun    = 0;
    int              failures    = 0;
    int              donesSeen   = 0;
    int              opsExpected = 0;
    logic [XLEN-1:0] lastRes     = '0;
    logic [4:0]      lastRd      = '0;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    ex_muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .md_valid (md_valid),
        .func3    (func3),
        .Read1    (Read1),
        .Read2    (Read2),
        .rd       (rd),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_MD    (rd_MD)
    );

    // 10 ns clock; inputs change on the falling edge
    always #5 clk = ~clk;

    // Hard time limit so a hung sequencer can never stall the run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected
    // completion, and a pulse with nothing outstanding is an error
    always @(negedge clk) begin
        if (done === 1'b1) begin
            donesSeen++;
            if (expQ.size() == 0) begin
                testsRun++;
                failures++;
                $display("[TB] FAIL unexpectedDone: got done=1 (result 0x%08h), required done=0", result);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("result", result, monExp.res);
                checkOutput("rd_MD", {27'b0, rd_MD}, {27'b0, monExp.rdv});
            end
        end
    end

    // Present one instruction in EX at a falling edge and hold it until stall
    // drops. Cycle 0 is the acceptance cycle, so done should be seen in cycle
    // expLat+1 and stall should be high for expLat+1 cycles. The task returns
    // on the falling edge after EX has advanced, with md_valid still high.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rdv,
                                 input logic [31:0] expRes, input int expLat,
                                 input string name);
        int cyc;
        int stallCnt;
        int doneCyc;
        exp_t e;
        e.res = expRes;
        e.rdv = rdv;
        expQ.push_back(e);
        opsExpected++;
        md_valid = 1'b1;
        flush    = 1'b0;
        func3    = f3;
        Read1    = a;
        Read2    = b;
        rd       = rdv;
        stallCnt = 0;
        doneCyc  = -1;
        for (cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (done === 1'b1 && doneCyc < 0)
                doneCyc = cyc;
            if (stall !== 1'b1)
                break;
            stallCnt++;
            @(negedge clk);
        end
        if (cyc >= 100) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL %s_timeout: got stall still high after 100 cycles, required release", name);
        end
        checkOutput({name, "_latency"}, 32'(doneCyc - 1), 32'(expLat));
        checkOutput({name, "_stallCycles"}, 32'(stallCnt), 32'(expLat + 1));
        lastRes = expRes;
        lastRd  = rdv;
        @(negedge clk);
    endtask

    // Present an instruction without expecting it to complete
    task automatic startOnly(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rdv);
        md_valid = 1'b1;
        func3    = f3;
        Read1    = a;
        Read2    = b;
        rd       = rdv;
    endtask

    task automatic idleCycles(input int n);
        md_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        md_valid = 1'b0;
        flush    = 1'b0;
        func3    = 3'b000;
        Read1    = '0;
        Read2    = '0;
        rd       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_rd_MD", {27'b0, rd_MD}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic multiplies, back to back
        applyStimulus(MUL,    32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 34, "mul_7_m3");
        applyStimulus(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 34, "mulhu_max");
        idleCycles(2);
        applyStimulus(MULH,   32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 34, "mulh_min");
        applyStimulus(MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4, 32'hFFFFFFFF, 34, "mulhsu_m1_2");
        idleCycles(1);

        // Division, signed and unsigned
        applyStimulus(DIV,    32'hFFFFFFF9, 32'd2,        5'd5, 32'hFFFFFFFD, 34, "div_m7_2");
        applyStimulus(REM,    32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 34, "rem_m7_2");
        applyStimulus(DIVU,   32'hFFFFFFF9, 32'd2,        5'd7, 32'h7FFFFFFC, 34, "divu_big_2");
        idleCycles(1);

        // Fast paths
        applyStimulus(DIV,    32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1, "div_by0");
        applyStimulus(REMU,   32'd5,        32'd0,        5'd9,  32'd5,        1, "remu_by0");
        applyStimulus(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1, "div_ovf");
        applyStimulus(REM,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        1, "rem_ovf");
        idleCycles(2);

        // Flush in CALC: the sequencer goes idle on the next edge and no
        // done pulse appears
        startOnly(MUL, 32'd123, 32'd456, 5'd20);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        idleCycles(40);
        checkOutput("flush_result_kept", result, lastRes);
        checkOutput("flush_rd_kept", {27'b0, rd_MD}, {27'b0, lastRd});

        // Flush together with md_valid in IDLE: the instruction is not taken
        startOnly(DIVU, 32'd9, 32'd3, 5'd21);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        idleCycles(3);

        applyStimulus(DIVU, 32'd100, 32'd7, 5'd22, 32'd14, 34, "divu_after_flush");
        idleCycles(2);

        // Reset in the middle of CALC clears all outputs, then MULs follow
        // back to back with md_valid held high
        startOnly(MUL, 32'd11, 32'd13, 5'd23);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_done", {31'b0, done}, 32'd0);
        checkOutput("midreset_result", result, 32'd0);
        checkOutput("midreset_rd_MD", {27'b0, rd_MD}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(MUL, 32'd3,        32'd5,        5'd24, 32'd15, 34, "b2b_mul_a");
        applyStimulus(MUL, 32'h00010000, 32'h00010000, 5'd25, 32'd0,  34, "b2b_mul_b");
        applyStimulus(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd26, 32'd1,  34, "b2b_mul_c");
        idleCycles(40);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        checkOutput("done_count", 32'(donesSeen), 32'(opsExpected));

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Multi-cycle RV32M multiply/divide sequencer attached to the EX stage. It accepts an M-extension operation presented in EX and holds the pipeline with a stall while an iterative shift-add multiplier or restoring divider runs. It then returns a 32-bit result together with the forwarded rd. Single-cycle ALU operations never enter this block.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
md_valid  input  1  EX holds an M-extension instruction (opcode R, func7=0000001)
func3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Read1  input  XLEN  rs1 operand
Read2  input  XLEN  rs2 operand
rd  input  5  destination register, forwarded with the result
flush  input  1  kills the in-flight operation (branch/jump redirect)
stall  output  1  holds IF/ID/EX pipeline registers
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse; result and rd_MD valid
result  output  XLEN  operation result
rd_MD  output  5  latched rd of the completed operation

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, done=0, busy=0, result=0, rd_MD=0, internal accumulators cleared. Reset dominates flush and md_valid.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: when md_valid=1 at an edge, latch Read1, Read2, func3 and rd; go to PREP. Operand changes after acceptance are ignored.
- PREP (1 cycle): compute operand magnitudes. Signed for MULH/DIV/REM and for rs1 of MULHSU; raw otherwise. Record result sign, load iteration counter = XLEN.
  - Fast paths go directly to DONE:
    - divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
    - signed overflow 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - Otherwise go to CALC.
- CALC (XLEN cycles, counter decrements each cycle, exit when counter reaches 1→0).
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring, one quotient bit per cycle; remainder kept XLEN+1 bits.
- FIX (1 cycle): negate if needed.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Select output: MUL uses the low word; MULH/MULHSU/MULHU use the high word.
  - Go to DONE.
- DONE (1 cycle): done=1, result and rd_MD valid; next state IDLE unconditionally.
- Latency, with acceptance at edge E0:
  - normal path: done high between E(XLEN+2) and E(XLEN+3), i.e. E34–E35; EX advances at E35.
  - fast path: done high between E1 and E2.
- stall = md_valid & (state != DONE), combinational. It is therefore high in the acceptance cycle itself and low in DONE, so the instruction leaves EX at the same edge the FSM returns to IDLE. There is no retrigger on the same instruction.
- busy = (state != IDLE). done is registered, with no combinational path from inputs.
- result and rd_MD hold their last value until the next DONE. done is 0 in every other state.
- flush=1 at an edge in any state: go to IDLE, no done pulse, result unchanged.
  - A flush coinciding with md_valid in IDLE: flush wins; the operation is not accepted.
  - A flush in DONE: done still deasserts next cycle; the result already produced is left as-is, and the pipeline discards it.
- Arithmetic is modulo 2^XLEN; all sign handling follows the RISC-V M specification.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), then MULHU 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL: result=0xFFFFFFEB, done exactly 34 cycles after acceptance, stall high for 35 cycles.
  - MULHU: result=0xFFFFFFFE.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed and unsigned division:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Fast paths:
  - DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, each with done 1 cycle after acceptance.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Flush during CALC (cycle 10): busy drops next edge and no done pulse occurs. A following DIVU 100 / 7 then returns 14, with rd_MD equal to the new rd.
- Reset asserted mid-CALC, then back-to-back MUL ops with md_valid held continuously: all outputs return to 0; each op is accepted exactly once and produces exactly one done pulse.
